// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply-divide unit: operation codes,
// FSM states and small decode helpers used by the accept stage.
package hilo_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Operations that run through the iterative datapath.
  function automatic logic is_iter_op(logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(logic [3:0] op);
    case (op)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle unsigned core: shift-add multiply or restoring divide.
// Multiply leaves the product in {hi,lo}; divide leaves remainder in hi, quotient in lo.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   sum, rs, diff;

  assign sum  = hi_q + (lo_q[0] ? {1'b0, b_q} : '0);
  assign rs   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  // MSB of diff set means the trial subtraction borrowed, so restore.
  assign diff = rs - {1'b0, b_q};

  always_comb begin
    // NOTE: defaults first so every path assigns hi_d/lo_d and no latch is inferred.
    hi_d = hi_q;
    lo_d = lo_q;
    if (load_i) begin
      hi_d = '0;
      lo_d = a_i;
    end else if (step_i) begin
      if (div_i) begin
        if (!diff[WIDTH]) begin
          hi_d = diff;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rs;
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = {1'b0, sum[WIDTH:1]};
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: working registers are reset too, so no X can leak into HI/LO later.
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (load_i) b_q <= b_i;
    end
  end

  assign hi_o = hi_q[WIDTH-1:0];
  assign lo_o = lo_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: accepts one request at a time, runs WIDTH
// iteration cycles plus a FIN cycle for sign fix-up, accumulate and HI/LO write.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       op_q;
  logic             neg_q, neg_rem_q, div_zero_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;

  logic             neg_a, neg_b, load;
  logic [WIDTH-1:0] a_mag, b_mag, iter_hi, iter_lo;
  logic [WIDTH-1:0] quot, rem;
  logic [2*WIDTH-1:0] prod_mag, prod, acc, fin_res;

  assign neg_a = is_signed_op(Op) && SrcA[WIDTH-1];
  assign neg_b = is_signed_op(Op) && SrcB[WIDTH-1];
  assign a_mag = neg_a ? -SrcA : SrcA;
  assign b_mag = neg_b ? -SrcB : SrcB;
  assign load  = !rst && !Flush && (state_q == ST_IDLE) && Start && is_iter_op(Op);

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .step_i (state_q == ST_CALC),
    .div_i  (is_div_op(op_q)),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .hi_o   (iter_hi),
    .lo_o   (iter_lo)
  );

  // Accumulating ops read the live {HI,LO} in FIN, not a copy from acceptance.
  always_comb begin
    prod_mag = {iter_hi, iter_lo};
    prod     = neg_q ? -prod_mag : prod_mag;
    acc      = {hi_q, lo_q};
    quot     = neg_q ? -iter_lo : iter_lo;
    rem      = neg_rem_q ? -iter_hi : iter_hi;
    case (op_q)
      OP_MADD, OP_MADDU: fin_res = acc + prod;
      OP_MSUB, OP_MSUBU: fin_res = acc - prod;
      OP_DIV, OP_DIVU:   fin_res = div_zero_q ? {a_q, {WIDTH{1'b1}}} : {rem, quot};
      default:           fin_res = prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_NOP;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      if (Flush) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (Start) begin
              case (Op)
                OP_MTHI: begin
                  hi_q   <= SrcA;
                  done_q <= 1'b1;
                end
                OP_MTLO: begin
                  lo_q   <= SrcA;
                  done_q <= 1'b1;
                end
                default: begin
                  if (is_iter_op(Op)) begin
                    state_q    <= ST_CALC;
                    busy_q     <= 1'b1;
                    cnt_q      <= '0;
                    op_q       <= Op;
                    neg_q      <= neg_a ^ neg_b;
                    neg_rem_q  <= neg_a;
                    div_zero_q <= (SrcB == '0);
                    a_q        <= SrcA;
                  end
                end
              endcase
            end
          end
          ST_CALC: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_q <= ST_FIN;
          end
          ST_FIN: begin
            hi_q    <= fin_res[2*WIDTH-1:WIDTH];
            lo_q    <= fin_res[WIDTH-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign HiOut = hi_q;
  assign LoOut = lo_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal range 4..64. HI and LO are each WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Start, input, 1 bit: requests an operation this cycle.
REQ-005 The block SHALL have port Op, input, 4 bits: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO; 11-15 are treated as NOP.
REQ-006 The block SHALL have port SrcA, input, WIDTH bits: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 The block SHALL have port SrcB, input, WIDTH bits: multiplier or divisor.
REQ-008 The block SHALL have port Flush, input, 1 bit: aborts any in-flight operation.
REQ-009 The block SHALL have port HiOut, output, WIDTH bits: the current HI register.
REQ-010 The block SHALL have port LoOut, output, WIDTH bits: the current LO register.
REQ-011 The block SHALL have port Busy, output, 1 bit: high while a multi-cycle operation is in flight.
REQ-012 The block SHALL have port Done, output, 1 bit: one-cycle pulse after any HI/LO update.

Function
REQ-013 A request SHALL be accepted only at an edge where Start=1, Busy=0 and Flush=0; otherwise Start is ignored and no request is queued.
REQ-014 The FSM SHALL use three states: IDLE, CALC (exactly WIDTH cycles, one operand bit per cycle) and FIN (one cycle: sign fix-up, accumulate, HI/LO write); then return to IDLE.
REQ-015 For ops 1-8 accepted at edge k, Busy SHALL be 1 after edges k..k+WIDTH and 0 after edge k+WIDTH+1. After that edge, HI/LO SHALL hold the new value and Done SHALL be 1 for exactly that cycle.
REQ-016 MTHI/MTLO SHALL write SrcA into HI or LO at the accepting edge with Busy kept 0, pulse Done in the next cycle, and leave the other half unchanged.
REQ-017 A NOP request SHALL change nothing and SHALL NOT pulse Done.
REQ-018 MULT/MULTU SHALL set {HI,LO} to the full 2*WIDTH-bit product, signed or unsigned respectively.
REQ-019 MADD/MADDU SHALL set {HI,LO} = {HI,LO} + product, wrapping modulo 2^(2*WIDTH).
REQ-020 MSUB/MSUBU SHALL set {HI,LO} = {HI,LO} - product, wrapping modulo 2^(2*WIDTH).
REQ-021 For MADD/MADDU/MSUB/MSUBU, the {HI,LO} value used SHALL be the value present in FIN.
REQ-022 DIV/DIVU SHALL set LO = quotient and HI = remainder, using restoring division. For DIV, the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-023 For divide by zero (both DIV and DIVU), LO SHALL be all ones and HI SHALL be SrcA.
REQ-024 For DIV with SrcA = most-negative and SrcB = -1, LO SHALL be most-negative and HI SHALL be 0.
REQ-025 Divide by zero and the DIV overflow case SHALL still take the full latency.
REQ-026 Operands SHALL be captured at acceptance, so later changes on SrcA/SrcB have no effect.
REQ-027 Flush=1 SHALL return the FSM to IDLE at that edge, leave HI/LO unchanged and suppress Done. This includes Flush arriving in FIN, since Flush has priority over the FIN write.
REQ-028 The block SHALL accept a new Start in the cycle Done is high.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, HiOut=0, LoOut=0, Busy=0 and Done=0, overriding Start and Flush, including mid-operation.
REQ-030 All internal working registers SHALL be reset, so no X reaches any output after the first reset edge.

Structure
REQ-031 The Op encodings (4-bit constants) and FSM state encodings SHALL live in a shared package, hilo_pkg, for use by the decode stage.
REQ-032 The iterative datapath SHALL be one sub-module, muldiv_iter (shift-add multiply / restoring divide on magnitudes). Sign handling, accumulate and the HI/LO registers SHALL remain in hilo_muldiv.

Verification (WIDTH=32)
REQ-033 MULT A=0xFFFFFFFE, B=3 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy low, Done pulses once.
REQ-034 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then MADD A=2, B=3 -> LO=0x00000007, HI unchanged; then MSUBU A=1, B=8 -> HI=0xFFFFFFFD, LO=0xFFFFFFFF.
REQ-035 DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=100; DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
REQ-036 MTHI 0x1234 and MTLO 0x5678 on consecutive cycles -> HI=0x1234 and LO=0x5678 with no Busy; Start held during a MULT -> ignored, result unaffected.
REQ-037 Flush at cycle 10 of a MULT, and separately Flush in FIN -> HI/LO keep their prior values, no Done; rst at cycle 5 -> all outputs 0 at the next cycle.
